// File: rtl/lm32_dtlb_walker.sv
// Two-level page-table walker that refills the LM32 data TLB over a Wishbone
// master port. Faults are reported as a one-cycle pulse with a cause code.
module lm32_dtlb_walker #(
  parameter int timeout_cycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable,
  input  logic [31:0] pt_base,
  input  logic        miss,
  input  logic [31:0] miss_vaddr,
  input  logic        miss_store,
  output logic [31:0] dw_adr_o,
  output logic        dw_cyc_o,
  output logic        dw_stb_o,
  output logic [3:0]  dw_sel_o,
  output logic        dw_we_o,
  input  logic [31:0] dw_dat_i,
  input  logic        dw_ack_i,
  input  logic        dw_err_i,
  output logic        tlb_update,
  output logic [31:0] tlb_vaddr,
  output logic [31:0] tlb_paddr,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_vaddr
);

  localparam int CW = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {IDLE, FETCH_PDE, FETCH_PTE, UPDATE, FAULT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   vaddr_q;
  logic          store_q;
  logic [19:0]   pd_base_q, table_base_q, pte_q;
  logic [1:0]    cause_q, cause_d;
  logic          gap_q;
  logic [CW-1:0] cnt_q;
  logic          bus_active, timed_out;

  // Bus handshake: cyc/stb stay high for a whole fetch until ack, err or the
  // timeout cycle; err beats ack, and ack on the timeout cycle still counts.
  // gap_q holds the bus idle for one cycle between the PDE and PTE fetches.
  assign bus_active = (state_q == FETCH_PDE) || (state_q == FETCH_PTE && !gap_q);
  assign timed_out  = (cnt_q == CW'(timeout_cycles - 1));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (enable && miss) state_d = FETCH_PDE;
      FETCH_PDE: begin
        if (dw_err_i) begin
          state_d = FAULT; cause_d = 2'b11;
        end else if (dw_ack_i) begin
          if (!dw_dat_i[0]) begin
            state_d = FAULT; cause_d = 2'b01;
          end else begin
            state_d = FETCH_PTE;
          end
        end else if (timed_out) begin
          state_d = FAULT; cause_d = 2'b11;
        end
      end
      FETCH_PTE: begin
        if (bus_active) begin
          if (dw_err_i) begin
            state_d = FAULT; cause_d = 2'b11;
          end else if (dw_ack_i) begin
            if (!dw_dat_i[0]) begin
              state_d = FAULT; cause_d = 2'b01;
            end else if (store_q && !dw_dat_i[1]) begin
              state_d = FAULT; cause_d = 2'b10;
            end else begin
              state_d = UPDATE;
            end
          end else if (timed_out) begin
            state_d = FAULT; cause_d = 2'b11;
          end
        end
      end
      UPDATE:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      vaddr_q      <= '0;
      store_q      <= 1'b0;
      pd_base_q    <= '0;
      table_base_q <= '0;
      pte_q        <= '0;
      cause_q      <= 2'b00;
      gap_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      gap_q   <= (state_q == FETCH_PDE) && (state_d == FETCH_PTE);
      cnt_q   <= (bus_active && state_d == state_q) ? cnt_q + CW'(1) : '0;
      if (state_q == IDLE && state_d == FETCH_PDE) begin
        vaddr_q   <= miss_vaddr;
        store_q   <= miss_store;
        pd_base_q <= pt_base[31:12];
      end
      if (state_q == FETCH_PDE && state_d == FETCH_PTE) table_base_q <= dw_dat_i[31:12];
      if (state_q == FETCH_PTE && state_d == UPDATE)    pte_q        <= dw_dat_i[31:12];
    end
  end

  always_comb begin
    dw_adr_o = 32'h0;
    if (state_q == FETCH_PDE)  dw_adr_o = {pd_base_q, vaddr_q[31:22], 2'b00};
    else if (bus_active)       dw_adr_o = {table_base_q, vaddr_q[21:12], 2'b00};
  end

  assign dw_cyc_o    = bus_active;
  assign dw_stb_o    = bus_active;
  assign dw_sel_o    = bus_active ? 4'hF : 4'h0;
  assign dw_we_o     = 1'b0;
  assign busy        = (state_q != IDLE);
  assign tlb_update  = (state_q == UPDATE);
  assign tlb_vaddr   = tlb_update ? {vaddr_q[31:12], 12'h0} : 32'h0;
  assign tlb_paddr   = tlb_update ? {pte_q, 12'h0} : 32'h0;
  assign fault       = (state_q == FAULT);
  assign fault_cause = fault ? cause_q : 2'b00;
  assign fault_vaddr = fault ? vaddr_q : 32'h0;

  logic unused_bits;
  assign unused_bits = &{1'b0, pt_base[11:0], dw_dat_i[11:2]};

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Directed bench for lm32_dtlb_walker: successful walks, PDE/PTE faults,
// bus error and timeout, miss handling and mid-walk reset.
module tb_lm32_dtlb_walker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] pt_base = 32'h0010_0000;
  logic        miss = 1'b0;
  logic [31:0] miss_vaddr = 32'h0;
  logic        miss_store = 1'b0;
  logic [31:0] dw_adr_o;
  logic        dw_cyc_o, dw_stb_o, dw_we_o;
  logic [3:0]  dw_sel_o;
  logic [31:0] dw_dat_i = 32'h0;
  logic        dw_ack_i = 1'b0;
  logic        dw_err_i = 1'b0;
  logic        tlb_update, busy, fault;
  logic [31:0] tlb_vaddr, tlb_paddr, fault_vaddr;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  lm32_dtlb_walker dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .pt_base(pt_base),
    .miss(miss), .miss_vaddr(miss_vaddr), .miss_store(miss_store),
    .dw_adr_o(dw_adr_o), .dw_cyc_o(dw_cyc_o), .dw_stb_o(dw_stb_o),
    .dw_sel_o(dw_sel_o), .dw_we_o(dw_we_o), .dw_dat_i(dw_dat_i),
    .dw_ack_i(dw_ack_i), .dw_err_i(dw_err_i), .tlb_update(tlb_update),
    .tlb_vaddr(tlb_vaddr), .tlb_paddr(tlb_paddr), .busy(busy),
    .fault(fault), .fault_cause(fault_cause), .fault_vaddr(fault_vaddr)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b1; miss = 1'b0; enable = 1'b0; dw_ack_i = 1'b0; dw_err_i = 1'b0;
    pt_base = 32'h0010_0000;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic start_miss(input logic [31:0] va, input logic st);
    enable = 1'b1; miss = 1'b1; miss_vaddr = va; miss_store = st;
    @(negedge clk_i);
    miss = 1'b0;
  endtask

  task automatic bus_reply(input logic [31:0] d, input logic a, input logic e);
    dw_dat_i = d; dw_ack_i = a; dw_err_i = e;
    @(negedge clk_i);
    dw_dat_i = 32'h0; dw_ack_i = 1'b0; dw_err_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if ({dw_cyc_o, dw_stb_o, dw_we_o, dw_sel_o} !== 7'h0) begin errors++; $display("FAIL reset_bus: got %b want 0", {dw_cyc_o, dw_stb_o, dw_we_o, dw_sel_o}); end
    checks++; if (dw_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", dw_adr_o); end
    checks++; if ({tlb_update, tlb_vaddr, tlb_paddr} !== 65'h0) begin errors++; $display("FAIL reset_tlb: got %0b %h %h want 0", tlb_update, tlb_vaddr, tlb_paddr); end
    checks++; if ({fault, fault_cause, fault_vaddr} !== 35'h0) begin errors++; $display("FAIL reset_fault: got %0b %b %h want 0", fault, fault_cause, fault_vaddr); end
  endtask

  task automatic test_enable_gate();
    enable = 1'b0; miss = 1'b1; miss_vaddr = 32'h4000_3ABC;
    repeat (3) @(negedge clk_i);
    checks++; if (busy !== 1'b0 || dw_cyc_o !== 1'b0) begin errors++; $display("FAIL miss_disabled: got busy=%0b cyc=%0b want 0 0", busy, dw_cyc_o); end
    miss = 1'b0;
  endtask

  task automatic test_basic_walk();
    start_miss(32'h4000_3ABC, 1'b0);
    pt_base = 32'hFFFF_F000;
    enable  = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL walk_busy: got %0b want 1", busy); end
    checks++; if ({dw_cyc_o, dw_stb_o, dw_we_o, dw_sel_o} !== 7'b110_1111) begin errors++; $display("FAIL pde_bus: got %b want 1101111", {dw_cyc_o, dw_stb_o, dw_we_o, dw_sel_o}); end
    checks++; if (dw_adr_o !== 32'h0010_0400) begin errors++; $display("FAIL pde_adr: got %h want 00100400", dw_adr_o); end
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    checks++; if (dw_cyc_o !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_gap: got cyc=%0b busy=%0b want 0 1", dw_cyc_o, busy); end
    @(negedge clk_i);
    checks++; if (dw_cyc_o !== 1'b1 || dw_adr_o !== 32'h0020_000C) begin errors++; $display("FAIL pte_adr: got cyc=%0b adr=%h want 1 0020000c", dw_cyc_o, dw_adr_o); end
    bus_reply(32'h0ABC_D001, 1'b1, 1'b0);
    checks++; if (tlb_update !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL walk_update: got upd=%0b fault=%0b want 1 0", tlb_update, fault); end
    checks++; if (tlb_vaddr !== 32'h4000_3000 || tlb_paddr !== 32'h0ABC_D000) begin errors++; $display("FAIL walk_entry: got %h %h want 40003000 0abcd000", tlb_vaddr, tlb_paddr); end
    @(negedge clk_i);
    checks++; if (tlb_update !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL walk_done: got upd=%0b busy=%0b want 0 0", tlb_update, busy); end
    pt_base = 32'h0010_0000;
  endtask

  task automatic test_pde_invalid();
    start_miss(32'h4000_3ABC, 1'b0);
    bus_reply(32'h0020_0000, 1'b1, 1'b0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin errors++; $display("FAIL pde_fault: got %0b cause=%b want 1 01", fault, fault_cause); end
    checks++; if (fault_vaddr !== 32'h4000_3ABC) begin errors++; $display("FAIL pde_fault_va: got %h want 40003abc", fault_vaddr); end
    checks++; if (tlb_update !== 1'b0 || dw_cyc_o !== 1'b0) begin errors++; $display("FAIL pde_fault_quiet: got upd=%0b cyc=%0b want 0 0", tlb_update, dw_cyc_o); end
    @(negedge clk_i);
    checks++; if (fault !== 1'b0 || busy !== 1'b0 || dw_cyc_o !== 1'b0) begin errors++; $display("FAIL pde_fault_end: got fault=%0b busy=%0b cyc=%0b want 0 0 0", fault, busy, dw_cyc_o); end
  endtask

  task automatic test_store();
    start_miss(32'h4000_3ABC, 1'b1);
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    @(negedge clk_i);
    bus_reply(32'h0ABC_D001, 1'b1, 1'b0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b10 || tlb_update !== 1'b0) begin errors++; $display("FAIL store_wp: got fault=%0b cause=%b upd=%0b want 1 10 0", fault, fault_cause, tlb_update); end
    @(negedge clk_i);
    start_miss(32'h4000_3ABC, 1'b1);
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    @(negedge clk_i);
    bus_reply(32'h0ABC_D003, 1'b1, 1'b0);
    checks++; if (tlb_update !== 1'b1 || tlb_paddr !== 32'h0ABC_D000 || fault !== 1'b0) begin errors++; $display("FAIL store_ok: got upd=%0b pa=%h fault=%0b want 1 0abcd000 0", tlb_update, tlb_paddr, fault); end
    @(negedge clk_i);
  endtask

  task automatic test_bus_errors();
    start_miss(32'h1234_5678, 1'b0);
    bus_reply(32'h0020_0001, 1'b1, 1'b1);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b11 || dw_cyc_o !== 1'b0) begin errors++; $display("FAIL ack_err: got fault=%0b cause=%b cyc=%0b want 1 11 0", fault, fault_cause, dw_cyc_o); end
    @(negedge clk_i);
    start_miss(32'h1234_5678, 1'b0);
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    @(negedge clk_i);
    bus_reply(32'h0, 1'b0, 1'b1);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b11 || fault_vaddr !== 32'h1234_5678) begin errors++; $display("FAIL pte_err: got fault=%0b cause=%b va=%h want 1 11 12345678", fault, fault_cause, fault_vaddr); end
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    int n;
    start_miss(32'h4000_3ABC, 1'b0);
    n = 0;
    while (dw_cyc_o && n < 400) begin
      n++;
      @(negedge clk_i);
    end
    checks++; if (n !== 256) begin errors++; $display("FAIL timeout_len: got %0d cycles want 256", n); end
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b11) begin errors++; $display("FAIL timeout_fault: got %0b cause=%b want 1 11", fault, fault_cause); end
    @(negedge clk_i);
    start_miss(32'h4000_3ABC, 1'b0);
    repeat (255) @(negedge clk_i);
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    checks++; if (fault !== 1'b0 || busy !== 1'b1 || dw_cyc_o !== 1'b0) begin errors++; $display("FAIL ack_on_timeout: got fault=%0b busy=%0b cyc=%0b want 0 1 0", fault, busy, dw_cyc_o); end
    @(negedge clk_i);
    bus_reply(32'h0ABC_D001, 1'b1, 1'b0);
    checks++; if (tlb_update !== 1'b1) begin errors++; $display("FAIL ack_on_timeout_upd: got %0b want 1", tlb_update); end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; miss = 1'b1; miss_vaddr = 32'h4000_3ABC; miss_store = 1'b0;
    @(negedge clk_i);
    miss_vaddr = 32'h8000_5000;
    checks++; if (dw_adr_o !== 32'h0010_0400) begin errors++; $display("FAIL second_miss_pde: got %h want 00100400", dw_adr_o); end
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    @(negedge clk_i);
    bus_reply(32'h0ABC_D001, 1'b1, 1'b0);
    checks++; if (tlb_update !== 1'b1 || tlb_vaddr !== 32'h4000_3000) begin errors++; $display("FAIL second_miss_upd: got upd=%0b va=%h want 1 40003000", tlb_update, tlb_vaddr); end
    @(negedge clk_i);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%0b want 0", busy); end
    @(negedge clk_i);
    checks++; if (busy !== 1'b1 || dw_adr_o !== 32'h0010_0800) begin errors++; $display("FAIL b2b_restart: got busy=%0b adr=%h want 1 00100800", busy, dw_adr_o); end
    miss = 1'b0;
    reset_dut();
  endtask

  task automatic test_reset_mid_pte();
    start_miss(32'h4000_3ABC, 1'b0);
    bus_reply(32'h0020_0001, 1'b1, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++; if (busy !== 1'b0 || dw_cyc_o !== 1'b0 || dw_stb_o !== 1'b0 || dw_sel_o !== 4'h0 || dw_adr_o !== 32'h0) begin errors++; $display("FAIL rst_mid_bus: got busy=%0b cyc=%0b stb=%0b sel=%h adr=%h want all 0", busy, dw_cyc_o, dw_stb_o, dw_sel_o, dw_adr_o); end
    checks++; if (fault !== 1'b0 || tlb_update !== 1'b0 || fault_cause !== 2'b00) begin errors++; $display("FAIL rst_mid_out: got fault=%0b upd=%0b cause=%b want 0 0 00", fault, tlb_update, fault_cause); end
    bus_reply(32'h0ABC_D001, 1'b1, 1'b0);
    checks++; if (tlb_update !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL late_ack: got upd=%0b busy=%0b fault=%0b want 0 0 0", tlb_update, busy, fault); end
    @(negedge clk_i);
    checks++; if (tlb_update !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_ack_after: got upd=%0b busy=%0b want 0 0", tlb_update, busy); end
  endtask

  initial begin
    test_reset();
    test_enable_gate();
    test_basic_walk();
    test_pde_invalid();
    test_store();
    test_bus_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_pte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
